multi_debounce: RTL and testbench
=================================

# multi_debounce

Parametrised N-channel debouncer for push-buttons and switches feeding the game FSM and VGA control logic. It has an internal sample-tick divider and a 2-flop input synchroniser per channel. Each channel uses a stability counter, so the required stable-sample count is programmable. Each channel provides a debounced level, single-cycle press and release pulses, and optional hold-to-repeat pulses for held buttons.

## Interface
- N, 4: number of independent channels.
- TICK_BITS, 20: sample tick period is 2^TICK_BITS sysclk cycles.
- STABLE, 3: consecutive differing samples required to change level; range 1..15.
- REPEAT_DELAY, 0: ticks after press before the first repeat pulse; 0 disables auto-repeat. Max 65535.
- REPEAT_RATE, 8: ticks between subsequent repeat pulses; must be ≥1 when repeat is enabled.

- sysclk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- btn_in  in  N  raw asynchronous button inputs.
- level  out  N  debounced level per channel.
- press  out  N  one-cycle pulse when level goes 0→1.
- release  out  N  one-cycle pulse when level goes 1→0.
- rpt  out  N  one-cycle auto-repeat pulse while level is held at 1.

## Operation
- **Tick generator**
  - TICK_BITS-bit free-running counter, shared by all channels.
  - tick is a one-cycle strobe in the cycle the counter equals all-ones; the counter then wraps to 0.
- **Synchroniser**
  - Per channel, s1 <= btn_in and s2 <= s1 on every sysclk.
  - Only s2 is sampled.
- **Stability counter (cnt, 4 bits, per channel)**, evaluated only on tick:
  - If s2 == level: cnt <= 0.
  - If s2 != level and cnt == STABLE-1: level <= s2, cnt <= 0. At the same edge, press <= s2 and release <= ~s2.
  - Otherwise: cnt <= cnt+1.
- **Pulse duration:** press and release are registered. They are high for exactly one cycle, in the first cycle in which the new level is visible, and 0 in all other cycles.
- **Auto-repeat (per channel; only when REPEAT_DELAY > 0)**
  - 16-bit rcnt and a flag first.
  - On a press event: rcnt <= 0, first <= 1.
  - On tick with level == 1 and no level change at that tick: rcnt <= rcnt+1.
    - If first and rcnt+1 == REPEAT_DELAY: rpt pulses, rcnt <= 0, first <= 0.
    - If !first and rcnt+1 == REPEAT_RATE: rpt pulses, rcnt <= 0.
  - When level == 0: rcnt and first are held at 0.
  - A release cancels any pending repeat.
  - rpt never coincides with press or release.
- **REPEAT_DELAY == 0:** rpt is tied to 0 and the repeat registers may be optimised away.
- **Channel independence:** channels are fully independent. Simultaneous events on several channels produce simultaneous pulses in the same cycle.
- **Reset:** all zero — tick counter, s1, s2, cnt, level, press, release, rpt, rcnt, first.
  - An input held high through reset yields press after the normal debounce latency following reset deassertion.
  - There is no spurious release at reset.

## Timing
- Synchroniser latency is 2 sysclk cycles from btn_in to s2.
- Debounce latency: level changes at the STABLE-th consecutive tick whose sampled s2 differs from level.
  - Worst case (2 + STABLE·2^TICK_BITS) cycles after a clean edge.
  - Best case (2 + (STABLE-1)·2^TICK_BITS + 1) cycles.
- Glitch rejection: any sampled bounce back to the current level restarts the count.
- STABLE = 1: level follows s2 on every tick with no filtering beyond sampling.
- First rpt occurs REPEAT_DELAY ticks after the press tick; subsequent rpt pulses follow every REPEAT_RATE ticks.
- Wrap-around: the tick counter wraps silently. rcnt cannot overflow because it is cleared at the compare value.
- Reset asserted mid-debounce or mid-repeat aborts the operation. Outputs are 0 in the cycle after reset is sampled high.

## Test plan
Bench parameters: N=2, TICK_BITS=2 (tick every 4 cycles), STABLE=3, REPEAT_DELAY=4, REPEAT_RATE=2.

1. **Reset state:** reset for 3 cycles with btn_in=2'b11, then deassert → level=0 and press=0 throughout reset; press[1:0]=2'b11 for one cycle at the 3rd tick after s2 is high; level=2'b11 thereafter.
2. **Bounce rejection:** btn_in[0] toggles 1,0,1 with period 4 cycles, aligned so the samples are 1,0,1, then holds 1 → no press until 3 consecutive 1-samples; exactly one press pulse; release never asserts.
3. **Release:** after level[0]=1, drop btn_in[0] to 0 → release[0] pulses once at the 3rd 0-sample tick; level[0]=0 in the same cycle; press and rpt stay 0.
4. **Auto-repeat:** hold btn_in[1]=1 → press[1] at tick T; rpt[1] at ticks T+4, T+6, T+8. Release → no rpt after level[1] falls.
5. **Independence:** channel 0 pressed while channel 1 releases on the same tick → press[0] and release[1] pulse in the same cycle.
6. **Reset mid-operation:** assert reset after 2 of 3 stable samples on channel 0 → cnt cleared; after deassertion, press requires a fresh 3 samples.

Source files
------------

// File: rtl/multi_debounce.sv
`default_nettype none
// ============================================================================
// Module      : multi_debounce
// Description : N-channel push-button / switch debouncer. A shared free-running
//               divider produces a sample tick every 2^TICK_BITS cycles. Each
//               channel has a 2-flop synchroniser, a stability counter that
//               needs STABLE consecutive differing samples to flip the
//               debounced level, registered press/release pulses and an
//               optional hold-to-repeat pulse generator.
// Ports       : i_sysclk   - system clock, all logic on rising edge
//               i_reset    - synchronous active-high reset
//               i_btn_in   - raw asynchronous button inputs [N]
//               o_level    - debounced level per channel [N]
//               o_press    - one-cycle pulse on level 0->1 [N]
//               o_release  - one-cycle pulse on level 1->0 [N]
//               o_rpt      - one-cycle auto-repeat pulse while held [N]
// Revision    : 1.0 - initial release
// ============================================================================
module multi_debounce #(
  parameter int N            = 4,
  parameter int TICK_BITS    = 20,
  parameter int STABLE       = 3,
  parameter int REPEAT_DELAY = 0,
  parameter int REPEAT_RATE  = 8
) (
  input  logic         i_sysclk,
  input  logic         i_reset,
  input  logic [N-1:0] i_btn_in,
  output logic [N-1:0] o_level,
  output logic [N-1:0] o_press,
  output logic [N-1:0] o_release,
  output logic [N-1:0] o_rpt
);

  // Count value reached on the last differing sample before the level flips.
  localparam logic [3:0] c_STABLE_LAST = 4'(STABLE - 1);

  // --------------------------------------------------------------------------
  // Shared sample-tick divider: strobe while the counter is all-ones, then it
  // wraps naturally to zero.
  // --------------------------------------------------------------------------
  logic [TICK_BITS-1:0] r_tick_cnt;
  logic                 w_tick;

  always_ff @(posedge i_sysclk) begin
    if (i_reset) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TICK_BITS'(1);
    end
  end

  assign w_tick = &r_tick_cnt;

  // --------------------------------------------------------------------------
  // Two-flop synchroniser for every raw input; only r_s2 is ever sampled.
  // --------------------------------------------------------------------------
  logic [N-1:0] r_s1;
  logic [N-1:0] r_s2;

  always_ff @(posedge i_sysclk) begin
    if (i_reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_btn_in;
      r_s2 <= r_s1;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel debounce and repeat logic.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [3:0] r_cnt;
    logic       r_level;
    logic       r_press;
    logic       r_release;
    logic       w_sample;
    logic       w_change;

    assign w_sample = r_s2[i];
    // Level flips on this tick: the STABLE-th consecutive differing sample.
    assign w_change = w_tick && (w_sample != r_level) && (r_cnt == c_STABLE_LAST);

    always_ff @(posedge i_sysclk) begin
      if (i_reset) begin
        r_cnt     <= 4'd0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        // Pulses are only ever high for the cycle right after a flip.
        r_press   <= 1'b0;
        r_release <= 1'b0;
        if (w_tick) begin
          if (w_sample == r_level) begin
            // Any bounce back to the current level restarts the count.
            r_cnt <= 4'd0;
          end else if (r_cnt == c_STABLE_LAST) begin
            r_level   <= w_sample;
            r_cnt     <= 4'd0;
            r_press   <= w_sample;
            r_release <= ~w_sample;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
      end
    end

    assign o_level[i]   = r_level;
    assign o_press[i]   = r_press;
    assign o_release[i] = r_release;

    if (REPEAT_DELAY > 0) begin : g_rpt
      localparam logic [15:0] c_DELAY = 16'(REPEAT_DELAY);
      localparam logic [15:0] c_RATE  = 16'(REPEAT_RATE);

      logic [15:0] r_rcnt;
      logic        r_first;
      logic        r_rpt;
      logic [15:0] w_rcnt_nxt;

      assign w_rcnt_nxt = r_rcnt + 16'd1;

      always_ff @(posedge i_sysclk) begin
        if (i_reset) begin
          r_rcnt  <= 16'd0;
          r_first <= 1'b0;
          r_rpt   <= 1'b0;
        end else begin
          r_rpt <= 1'b0;
          if (w_change) begin
            // A press arms the initial delay; a release disarms everything.
            // Either way no repeat can fire on a level-change tick.
            r_rcnt  <= 16'd0;
            r_first <= w_sample;
          end else if (!r_level) begin
            r_rcnt  <= 16'd0;
            r_first <= 1'b0;
          end else if (w_tick) begin
            if (r_first && (w_rcnt_nxt == c_DELAY)) begin
              r_rpt   <= 1'b1;
              r_rcnt  <= 16'd0;
              r_first <= 1'b0;
            end else if (!r_first && (w_rcnt_nxt == c_RATE)) begin
              r_rpt  <= 1'b1;
              r_rcnt <= 16'd0;
            end else begin
              r_rcnt <= w_rcnt_nxt;
            end
          end
        end
      end

      assign o_rpt[i] = r_rpt;
    end else begin : g_no_rpt
      assign o_rpt[i] = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_debounce
// Description : Self-checking bench for multi_debounce (N=2, tick every 4
//               cycles, STABLE=3, repeat delay 4 ticks, rate 2 ticks).
//               A hand-derived vector table, directed corner sequences and a
//               random phase checked against a tick-history reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_debounce;

  localparam int TP     = 4;   // cycles per sample tick
  localparam int STABLE = 3;
  localparam int RD     = 4;
  localparam int RR     = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn;
  logic [1:0] level, press, rel, rpt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  multi_debounce #(
    .N(2), .TICK_BITS(2), .STABLE(STABLE), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .i_sysclk (clk),
    .i_reset  (rst),
    .i_btn_in (btn),
    .o_level  (level),
    .o_press  (press),
    .o_release(rel),
    .o_rpt    (rpt)
  );

  // --------------------------------------------------------------------------
  // Reference model: edges since reset give the tick number; each channel keeps
  // the list of tick samples seen since its last level change and flips when
  // the most recent STABLE of them all disagree with the level. Repeat pulses
  // are derived from the distance in ticks to the press tick.
  // --------------------------------------------------------------------------
  int         m_e, m_tickno;
  logic [1:0] m_s1, m_s2, m_level, m_press, m_rel, m_rpt;
  int         m_ptick [2];
  bit         m_hist  [2][$];

  task automatic model_step(input logic r, input logic [1:0] b);
    bit smp, all_diff;
    int d, sz;
    m_press = '0; m_rel = '0; m_rpt = '0;
    if (r) begin
      m_e = 0; m_tickno = 0; m_s1 = '0; m_s2 = '0; m_level = '0;
      for (int ch = 0; ch < 2; ch++) m_hist[ch].delete();
    end else begin
      m_e++;
      if (m_e % TP == 0) begin
        m_tickno++;
        for (int ch = 0; ch < 2; ch++) begin
          smp = m_s2[ch];
          m_hist[ch].push_back(smp);
          if (m_hist[ch].size() > 32) void'(m_hist[ch].pop_front());
          sz = m_hist[ch].size();
          all_diff = (sz >= STABLE);
          if (all_diff)
            for (int k = 0; k < STABLE; k++)
              if (m_hist[ch][sz-1-k] == m_level[ch]) all_diff = 0;
          if (all_diff) begin
            m_level[ch] = smp;
            m_press[ch] = smp;
            m_rel[ch]   = !smp;
            m_hist[ch].delete();
            if (smp) m_ptick[ch] = m_tickno;
          end else if (m_level[ch]) begin
            d = m_tickno - m_ptick[ch];
            if (d == RD || (d > RD && (d - RD) % RR == 0)) m_rpt[ch] = 1'b1;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = b;
    end
  endtask

  task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, got, exp);
    end
  endtask

  // Apply one cycle of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic do_cycle(input logic r, input logic [1:0] b, input bit chk_model);
    rst = r;
    btn = b;
    @(posedge clk);
    cyc++;
    model_step(r, b);
    #1;
    if (chk_model) begin
      check("model_level",   level, m_level);
      check("model_press",   press, m_press);
      check("model_release", rel,   m_rel);
      check("model_rpt",     rpt,   m_rpt);
    end
  endtask

  // Targeted check on an integer event property.
  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] btn;
    int         n;      // number of cycles this row is held
    logic [1:0] lvl, pr, rl, rp;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p_at0, p_at1, r_at0, r_at1, n_p, n_r, n_rp;
    int hold_p;
    logic [1:0] b;

    rst = 1'b1;
    btn = 2'b11;

    // Both buttons held through reset, then held long enough to see the
    // 4-tick initial repeat delay, two 2-tick repeats, and a final release.
    tbl[0]  = '{1'b1, 2'b11,  3, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[1]  = '{1'b0, 2'b11, 11, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[2]  = '{1'b0, 2'b11,  1, 2'b11, 2'b11, 2'b00, 2'b00};
    tbl[3]  = '{1'b0, 2'b11, 15, 2'b11, 2'b00, 2'b00, 2'b00};
    tbl[4]  = '{1'b0, 2'b11,  1, 2'b11, 2'b00, 2'b00, 2'b11};
    tbl[5]  = '{1'b0, 2'b11,  7, 2'b11, 2'b00, 2'b00, 2'b00};
    tbl[6]  = '{1'b0, 2'b11,  1, 2'b11, 2'b00, 2'b00, 2'b11};
    tbl[7]  = '{1'b0, 2'b11,  7, 2'b11, 2'b00, 2'b00, 2'b00};
    tbl[8]  = '{1'b0, 2'b11,  1, 2'b11, 2'b00, 2'b00, 2'b11};
    tbl[9]  = '{1'b0, 2'b00,  7, 2'b11, 2'b00, 2'b00, 2'b00};
    tbl[10] = '{1'b0, 2'b00,  1, 2'b11, 2'b00, 2'b00, 2'b11};
    tbl[11] = '{1'b0, 2'b00,  3, 2'b11, 2'b00, 2'b00, 2'b00};
    tbl[12] = '{1'b0, 2'b00,  1, 2'b00, 2'b00, 2'b11, 2'b00};
    tbl[13] = '{1'b0, 2'b00,  4, 2'b00, 2'b00, 2'b00, 2'b00};

    for (int t = 0; t < 14; t++) begin
      for (int k = 0; k < tbl[t].n; k++) begin
        do_cycle(tbl[t].rst, tbl[t].btn, 1'b0);
        check($sformatf("tbl%0d_level", t),   level, tbl[t].lvl);
        check($sformatf("tbl%0d_press", t),   press, tbl[t].pr);
        check($sformatf("tbl%0d_release", t), rel,   tbl[t].rl);
        check($sformatf("tbl%0d_rpt", t),     rpt,   tbl[t].rp);
      end
    end

    // Bounce rejection then release on channel 0: samples 1,0,1,1,1 then 0s.
    do_cycle(1'b1, 2'b00, 1'b1);
    do_cycle(1'b1, 2'b00, 1'b1);
    p_at0 = -1; r_at0 = -1; n_p = 0; n_r = 0; n_rp = 0;
    for (int c = 1; c <= 40; c++) begin
      b = 2'b00;
      b[0] = (c <= 4) ? 1'b1 : (c <= 8) ? 1'b0 : (c <= 20) ? 1'b1 : 1'b0;
      do_cycle(1'b0, b, 1'b1);
      if (press[0]) begin n_p++; p_at0 = c; end
      if (rel[0]) begin
        n_r++; r_at0 = c;
        check("release_level_same_cycle", level, 2'b00);
      end
      if (rpt[0]) n_rp++;
    end
    check_int("bounce_press_count", n_p, 1);
    check_int("bounce_press_cycle", p_at0, 20);
    check_int("release_count", n_r, 1);
    check_int("release_cycle", r_at0, 32);
    check_int("release_no_rpt", n_rp, 0);

    // Independence: channel 1 held, then both flip so that channel 0 presses
    // and channel 1 releases on the same tick.
    do_cycle(1'b1, 2'b00, 1'b1);
    do_cycle(1'b1, 2'b00, 1'b1);
    p_at0 = -1; p_at1 = -1; r_at1 = -1;
    for (int c = 1; c <= 30; c++) begin
      do_cycle(1'b0, (c <= 12) ? 2'b10 : 2'b01, 1'b1);
      if (press[1]) p_at1 = c;
      if (press[0]) p_at0 = c;
      if (rel[1])   r_at1 = c;
      if (press[0] && rel[1]) check("indep_same_cycle", {rel[1], press[0]}, 2'b11);
    end
    check_int("indep_press1_cycle", p_at1, 12);
    check_int("indep_press0_cycle", p_at0, 24);
    check_int("indep_release1_cycle", r_at1, 24);

    // Reset after two stable samples: a fresh three samples are then needed.
    do_cycle(1'b1, 2'b00, 1'b1);
    do_cycle(1'b1, 2'b00, 1'b1);
    for (int c = 1; c <= 8; c++) do_cycle(1'b0, 2'b01, 1'b1);
    do_cycle(1'b1, 2'b01, 1'b1);
    check("midreset_outputs_zero", level | press | rel | rpt, 2'b00);
    do_cycle(1'b1, 2'b01, 1'b1);
    p_at0 = -1;
    for (int c = 1; c <= 16; c++) begin
      do_cycle(1'b0, 2'b01, 1'b1);
      if (press[0] && p_at0 < 0) p_at0 = c;
    end
    check_int("midreset_press_cycle", p_at0, 12);

    // Random phase: segments with different bounce densities and rare resets.
    b = 2'b00;
    hold_p = 8;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) begin
        case ($urandom_range(0, 2))
          0:       hold_p = 2;
          1:       hold_p = 20;
          default: hold_p = 80;
        endcase
      end
      for (int ch = 0; ch < 2; ch++)
        if ($urandom_range(0, hold_p - 1) == 0) b[ch] = ~b[ch];
      do_cycle(($urandom_range(0, 499) == 0), b, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
